truth_table_sweeper: RTL and testbench

- Self-checking sequencer for the 4-input combinational function blocks (f(A,B,C,D)) exercised in lab exercises 2a/2b.
- On start, drives every input combination 0..2^N_IN-1 in ascending order onto the function under test, with {A,B,C,D} = vec_out MSB..LSB.
- Waits a settle time per vector, samples f, compares it against a minterm mask and reports pass/fail plus the captured truth table.
- Replaces hand-written 16-step stimulus sequences with a synthesizable on-chip checker.

---
 rtl/truth_table_sweeper_if.sv | 25 ++
 rtl/truth_table_sweeper.sv | 105 ++++++++++
 tb/tb_truth_table_sweeper.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bundles the sweep control, stimulus vector and result signals.
// The sweeper takes the master side; the function under test and the host take the slave side.
interface truth_table_sweeper_if #(
   parameter int N_IN = 4
);
   logic                     start;
   logic [(1 << N_IN)-1:0]   expected;
   logic                     f_in;
   logic [N_IN-1:0]          vec_out;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic [(1 << N_IN)-1:0]   result;
   logic [N_IN:0]            err_count;

   modport master (
      input  start, expected, f_in,
      output vec_out, busy, done, pass, result, err_count
   );

   modport slave (
      output start, expected, f_in,
      input  vec_out, busy, done, pass, result, err_count
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN input vectors, holds each DWELL cycles, samples f_in and checks it against a minterm mask.
// Each vector takes DWELL+1 cycles; start is ignored while busy. TT_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sweeper #(
   parameter int N_IN  = 4,
   parameter int DWELL = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   truth_table_sweeper_if.master   bus
);

   localparam int NVEC = 1 << N_IN;
   localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
   localparam logic [N_IN-1:0] VEC_LAST   = '1;
`ifdef TT_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [NVEC-1:0]   result_q, result_d;
   logic [N_IN:0]     err_q, err_d;
   logic              mismatch;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         vec_q    <= '0;
         dwell_q  <= '0;
         result_q <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         dwell_q  <= dwell_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      dwell_d  = dwell_q;
      result_d = result_q;
      err_d    = err_q;
      mismatch = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d  = APPLY;
               vec_d    = '0;
               dwell_d  = '0;
               result_d = '0;
               err_d    = '0;
            end
         end
         APPLY: begin
            if (dwell_q == DWELL_LAST) begin
               state_d = SAMPLE;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         SAMPLE: begin
            // f_in is only looked at here, so glitches while the vector settles are harmless
            result_d[vec_q] = bus.f_in;
            mismatch        = (bus.f_in != bus.expected[vec_q]);
            if (mismatch) begin
               err_d = err_q + 1'b1;
            end
            if ((vec_q == VEC_LAST) || (STOP_ON_FAIL && mismatch)) begin
               state_d = DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               dwell_d = '0;
               state_d = APPLY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.vec_out   = vec_q;
   assign bus.busy      = (state_q == APPLY) || (state_q == SAMPLE);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = (state_q == DONE) && (err_q == '0);
   assign bus.result    = result_q;
   assign bus.err_count = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised and directed sweeps of two sweepers (DWELL=2 and DWELL=1) against a per-sweep reference of the truth table.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef TT_STOP_ON_FAIL_EN
   localparam bit STOP_MODE = 1'b1;
`else
   localparam bit STOP_MODE = 1'b0;
`endif

   logic        rst_n;
   logic        start;
   logic        sel;
   logic        glitch;
   logic [15:0] model;
   logic [15:0] expected;

   truth_table_sweeper_if #(.N_IN(4)) if_a ();
   truth_table_sweeper_if #(.N_IN(4)) if_b ();

   assign if_a.start    = start & ~sel;
   assign if_b.start    = start & sel;
   assign if_a.expected = expected;
   assign if_b.expected = expected;
   assign if_a.f_in     = model[if_a.vec_out] ^ glitch;
   assign if_b.f_in     = model[if_b.vec_out] ^ glitch;

   truth_table_sweeper #(.N_IN(4), .DWELL(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   truth_table_sweeper #(.N_IN(4), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

   logic [3:0]  vec_o;
   logic        busy_o, done_o, pass_o;
   logic [15:0] result_o;
   logic [4:0]  err_o;
   assign vec_o    = sel ? if_b.vec_out   : if_a.vec_out;
   assign busy_o   = sel ? if_b.busy      : if_a.busy;
   assign done_o   = sel ? if_b.done      : if_a.done;
   assign pass_o   = sel ? if_b.pass      : if_a.pass;
   assign result_o = sel ? if_b.result    : if_a.result;
   assign err_o    = sel ? if_b.err_count : if_a.err_count;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "/busy"},   busy_o,   0);
      chk({tag, "/done"},   done_o,   0);
      chk({tag, "/pass"},   pass_o,   0);
      chk({tag, "/vec"},    vec_o,    0);
      chk({tag, "/result"}, result_o, 0);
      chk({tag, "/err"},    err_o,    0);
   endtask

   // poke_at: cycle index at which to pulse start mid-sweep; rst_at: cycle to pulse reset (-1 = never)
   task automatic run_sweep(input string tag, input logic [15:0] m, input logic [15:0] e,
                            input bit use_b, input int poke_at, input int rst_at);
      int          d, last, cycles, errs, k;
      logic [15:0] res;
      bit          hit_done;
      d    = use_b ? 1 : 2;
      res  = '0;
      errs = 0;
      last = 15;
      for (int i = 0; i < 16; i++) begin
         res[i] = m[i];
         if (m[i] != e[i]) begin
            errs++;
            if (STOP_MODE) begin
               last = i;
               break;
            end
         end
      end
      cycles = (last + 1) * (d + 1);

      sel      = use_b;
      model    = m;
      expected = e;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk({tag, "/start_busy"},   busy_o,   1);
      chk({tag, "/start_done"},   done_o,   0);
      chk({tag, "/start_err"},    err_o,    0);
      chk({tag, "/start_result"}, result_o, 0);

      k        = 0;
      hit_done = 1'b0;
      while (k < 400 && !hit_done) begin
         glitch = ((k % (d + 1)) != d) ? 1'($urandom) : 1'b0;
         if (k == poke_at) start = 1'b1;
         if (k == rst_at)  rst_n = 1'b0;
         tick();
         start = 1'b0;
         k++;
         if (k == rst_at + 1) begin
            rst_n  = 1'b1;
            glitch = 1'b0;
            chk_cleared({tag, "/midreset"});
            return;
         end
         if (done_o) begin
            hit_done = 1'b1;
         end else begin
            chk({tag, "/run_vec"},  vec_o,  k / (d + 1));
            chk({tag, "/run_busy"}, busy_o, 1);
            chk({tag, "/run_pass"}, pass_o, 0);
         end
      end
      glitch = 1'b0;
      chk({tag, "/done_cycle"}, k,        cycles);
      chk({tag, "/done"},       done_o,   1);
      chk({tag, "/busy"},       busy_o,   0);
      chk({tag, "/pass"},       pass_o,   (errs == 0) ? 1 : 0);
      chk({tag, "/err"},        err_o,    errs);
      chk({tag, "/result"},     result_o, res);
      chk({tag, "/vec"},        vec_o,    last);
   endtask

   initial begin
      logic [15:0] rm, flips;
      rst_n    = 1'b0;
      start    = 1'b0;
      sel      = 1'b0;
      glitch   = 1'b0;
      model    = '0;
      expected = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk_cleared("reset_a");
      sel = 1'b1;
      #1;
      chk_cleared("reset_b");

      run_sweep("correct",     16'hA5C3, 16'hA5C3, 1'b0, -1, -1);
      run_sweep("single",      16'hA5C3, 16'hA5C2, 1'b0, -1, -1);
      run_sweep("allwrong",    16'hA5C3, 16'h5A3C, 1'b0, -1, -1);
      run_sweep("busy_start",  16'hA5C3, 16'hA5C3, 1'b0, 10, -1);
      run_sweep("rst_mid",     16'hA5C3, 16'hA5C3, 1'b0, -1, 20);
      run_sweep("after_rst",   16'hA5C3, 16'hA5C3, 1'b0, -1, -1);
      run_sweep("dw1_correct", 16'hA5C3, 16'hA5C3, 1'b1, -1, -1);
      run_sweep("dw1_single",  16'hA5C3, 16'hA5C2, 1'b1, -1, -1);
      run_sweep("last_vec",    16'h8000, 16'h0000, 1'b0, -1, -1);

      for (int n = 0; n < 12; n++) begin
         rm = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       flips = '0;
            1:       flips = 16'(1) << $urandom_range(0, 15);
            default: flips = 16'($urandom);
         endcase
         run_sweep($sformatf("rand%0d", n), rm, rm ^ flips, 1'($urandom), -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
